// File: rtl/strobe_capture_pkg.sv
// strobe_capture_pkg: shared arbiter state encoding and constant-width helper
// Contents: arb_state_e (IDLE/ISSUE/GAP), clog2() ceiling log2 for parameter math.
package strobe_capture_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_GAP} arb_state_e;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/strobe_capture_fifo.sv
// strobe_capture_fifo: per-channel capture FIFO with pop-before-push on a full queue
// Ports: clk, rst_n (sync, active-low), push/wdata (write side),
//        pop/rdata (head word, read side), empty, full.
module strobe_capture_fifo
  import strobe_capture_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] wdata,
  input  logic              pop,
  output logic [DATA_W-1:0] rdata,
  output logic              empty,
  output logic              full
);
  localparam int AW = clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);
  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0] cnt_q, cnt_d;
  logic do_push, do_pop;
  // a pop in the same cycle frees the slot, so a full FIFO still accepts the push
  always_comb begin
    empty   = cnt_q == '0;
    full    = cnt_q == FULL_CNT;
    rdata   = mem_q[rd_q];
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
    wr_d    = wr_q + AW'(do_push);
    rd_d    = rd_q + AW'(do_pop);
    cnt_d   = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= wdata;
  end
endmodule

// File: rtl/strobe_capture_arbiter.sv
// strobe_capture_arbiter: synchronise async strobes, queue captured words per channel,
// and hand them to the transfer library one at a time with a round-robin grant and
// an enforced idle gap between pulses.
// Ports: CLK_66MHZ, RST_N (sync, active-low), ENABLE, STROBE_IN[NUM_CH],
//        DATA_IN[NUM_CH*DATA_W], CLR_OVERFLOW -> TRANSFER_OUT, TRANSFER_BYTE,
//        TRANSFER_CH, OVERFLOW[NUM_CH] (sticky), BUSY.
module strobe_capture_arbiter
  import strobe_capture_pkg::*;
#(
  parameter int NUM_CH     = 2,
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int GAP_CYCLES = 16,
  localparam int CH_W      = (NUM_CH > 1) ? clog2(NUM_CH) : 1
) (
  input  logic                     CLK_66MHZ,
  input  logic                     RST_N,
  input  logic                     ENABLE,
  input  logic [NUM_CH-1:0]        STROBE_IN,
  input  logic [NUM_CH*DATA_W-1:0] DATA_IN,
  input  logic                     CLR_OVERFLOW,
  output logic                     TRANSFER_OUT,
  output logic [DATA_W-1:0]        TRANSFER_BYTE,
  output logic [CH_W-1:0]          TRANSFER_CH,
  output logic [NUM_CH-1:0]        OVERFLOW,
  output logic                     BUSY
);
  localparam int GW = clog2(GAP_CYCLES) + 1;
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);
  arb_state_e state_q, state_d;
  logic [NUM_CH-1:0] sync1_q, sync2_q, hist_q, rise, push, pop, empty, full, ovf_q, ovf_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [CH_W-1:0] last_q, last_d, ch_q, ch_d, pick;
  logic [DATA_W-1:0] byte_q, byte_d;
  logic [DATA_W-1:0] head [NUM_CH];
  logic found;
  for (genvar g = 0; g < NUM_CH; g++) begin : g_fifo
    strobe_capture_fifo #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
      .clk  (CLK_66MHZ),
      .rst_n(RST_N),
      .push (push[g]),
      .wdata(DATA_IN[g*DATA_W +: DATA_W]),
      .pop  (pop[g]),
      .rdata(head[g]),
      .empty(empty[g]),
      .full (full[g])
    );
  end
  // sync/history flops reset high so a strobe already high at release is not an edge
  always_comb begin
    rise = sync2_q & ~hist_q;
    push = rise & {NUM_CH{ENABLE}};
  end
  // round-robin search starting just after the last granted channel
  always_comb begin
    pick  = last_q;
    found = 1'b0;
    for (int i = 1; i <= NUM_CH; i++) begin
      if (!found && !empty[(int'(last_q) + i) % NUM_CH]) begin
        found = 1'b1;
        pick  = CH_W'((int'(last_q) + i) % NUM_CH);
      end
    end
  end
  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    last_d  = last_q;
    ch_d    = ch_q;
    byte_d  = byte_q;
    ovf_d   = (CLR_OVERFLOW ? '0 : ovf_q) | (push & full & ~pop);
    if (state_q == ST_IDLE) begin
      if (found) begin
        state_d = ST_ISSUE;
        ch_d    = pick;
        byte_d  = head[pick];
      end
    end else if (state_q == ST_ISSUE) begin
      state_d = ST_GAP;
      last_d  = ch_q;
      gap_d   = '0;
    end else begin
      state_d = (gap_q == GAP_LAST) ? ST_IDLE : ST_GAP;
      gap_d   = (gap_q == GAP_LAST) ? '0 : gap_q + 1'b1;
    end
  end
  always_comb begin
    TRANSFER_OUT  = state_q == ST_ISSUE;
    pop           = TRANSFER_OUT ? NUM_CH'(1) << ch_q : '0;
    TRANSFER_BYTE = byte_q;
    TRANSFER_CH   = ch_q;
    OVERFLOW      = ovf_q;
    BUSY          = !(&empty) || state_q != ST_IDLE;
  end
  always_ff @(posedge CLK_66MHZ) begin
    if (!RST_N) begin
      sync1_q <= '1;
      sync2_q <= '1;
      hist_q  <= '1;
      state_q <= ST_IDLE;
      gap_q   <= '0;
      last_q  <= CH_W'(NUM_CH - 1);
      ch_q    <= '0;
      byte_q  <= '0;
      ovf_q   <= '0;
    end else begin
      sync1_q <= STROBE_IN;
      sync2_q <= sync1_q;
      hist_q  <= sync2_q;
      state_q <= state_d;
      gap_q   <= gap_d;
      last_q  <= last_d;
      ch_q    <= ch_d;
      byte_q  <= byte_d;
      ovf_q   <= ovf_d;
    end
  end
endmodule

// File: tb/tb_strobe_capture_arbiter.sv
// tb_strobe_capture_arbiter: self-checking bench for strobe_capture_arbiter
module tb_strobe_capture_arbiter;
  logic clk = 1'b0, rst_n = 1'b0, enable = 1'b0, clr = 1'b0;
  logic [1:0] strobe = '0;
  logic [15:0] data_in = '0;
  logic xfer_out, busy;
  logic [7:0] xfer_byte;
  logic [0:0] xfer_ch;
  logic [1:0] ovf;
  int n_vec = 0, n_bad = 0, cyc = 0;
  typedef struct {int ch; logic [7:0] data;} exp_t;
  typedef struct {int ch; logic [7:0] data; logic en; int lat; logic busy;} vec_t;
  exp_t sb[$];
  int pulse_cyc[$];
  vec_t vecs[6];
  strobe_capture_arbiter #(.NUM_CH(2), .DATA_W(8), .FIFO_DEPTH(4), .GAP_CYCLES(16)) dut (
    .CLK_66MHZ    (clk),
    .RST_N        (rst_n),
    .ENABLE       (enable),
    .STROBE_IN    (strobe),
    .DATA_IN      (data_in),
    .CLR_OVERFLOW (clr),
    .TRANSFER_OUT (xfer_out),
    .TRANSFER_BYTE(xfer_byte),
    .TRANSFER_CH  (xfer_ch),
    .OVERFLOW     (ovf),
    .BUSY         (busy)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic expect_word(input int ch, input logic [7:0] d);
    exp_t e;
    e.ch = ch;
    e.data = d;
    sb.push_back(e);
  endtask
  task automatic set_data(input int ch, input logic [7:0] d);
    data_in[ch*8 +: 8] = d;
  endtask
  task automatic fast_strobe(input int ch, input logic [7:0] d);
    set_data(ch, d);
    strobe[ch] = 1'b1;
    tick();
    strobe[ch] = 1'b0;
    tick();
    tick();
  endtask
  task automatic wait_pulse();
    logic got;
    got = 1'b0;
    for (int i = 0; i < 60 && !got; i++) begin
      tick();
      got = xfer_out;
    end
    check("pulse_timeout", got, 1);
  endtask
  task automatic wait_idle();
    logic idle;
    idle = 1'b0;
    for (int i = 0; i < 200 && !idle; i++) begin
      tick();
      idle = !busy;
    end
    check("idle_timeout", idle, 1);
  endtask
  task automatic trigger0(input logic [7:0] d);
    expect_word(0, d);
    set_data(0, d);
    strobe[0] = 1'b1;
    wait_pulse();
    strobe[0] = 1'b0;
  endtask
  // scoreboard: every pulse must match the oldest expected word
  always @(negedge clk) begin
    if (rst_n && xfer_out) begin
      exp_t e;
      if (sb.size() == 0) check("unexpected_pulse", 1, 0);
      else begin
        e = sb.pop_front();
        check("xfer_ch", xfer_ch, e.ch);
        check("xfer_byte", xfer_byte, e.data);
      end
      pulse_cyc.push_back(cyc);
    end
  end
  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    int lat;
    vecs[0] = '{0, 8'hA5, 1'b1, 4, 1'b1};
    vecs[1] = '{1, 8'h5A, 1'b1, 4, 1'b1};
    vecs[2] = '{0, 8'h3C, 1'b0, 0, 1'b0};
    vecs[3] = '{1, 8'hFF, 1'b1, 4, 1'b1};
    vecs[4] = '{1, 8'h00, 1'b1, 4, 1'b1};
    vecs[5] = '{0, 8'h81, 1'b1, 4, 1'b1};
    repeat (3) tick();
    check("rst_out", xfer_out, 0);
    check("rst_byte", xfer_byte, 0);
    check("rst_ch", xfer_ch, 0);
    check("rst_ovf", ovf, 0);
    check("rst_busy", busy, 0);
    rst_n = 1'b1;
    tick();
    // round robin right after reset: ch0, then ch1 ahead of a newer ch0 word
    pulse_cyc.delete();
    enable = 1'b1;
    expect_word(0, 8'h11);
    expect_word(1, 8'h22);
    expect_word(0, 8'h33);
    set_data(0, 8'h11);
    set_data(1, 8'h22);
    strobe = 2'b11;
    repeat (3) tick();
    strobe = 2'b00;
    repeat (3) tick();
    set_data(0, 8'h33);
    strobe[0] = 1'b1;
    repeat (3) tick();
    strobe[0] = 1'b0;
    wait_idle();
    check("rr_pulses", pulse_cyc.size(), 3);
    check("rr_gap1", pulse_cyc.size() > 1 ? pulse_cyc[1] - pulse_cyc[0] : 0, 18);
    check("rr_gap2", pulse_cyc.size() > 2 ? pulse_cyc[2] - pulse_cyc[1] : 0, 18);
    // table-driven single captures from idle
    foreach (vecs[i]) begin
      if (vecs[i].en) expect_word(vecs[i].ch, vecs[i].data);
      enable = vecs[i].en;
      set_data(vecs[i].ch, vecs[i].data);
      strobe[vecs[i].ch] = 1'b1;
      lat = 0;
      for (int j = 1; j <= 8; j++) begin
        tick();
        if (xfer_out && lat == 0) lat = j;
      end
      strobe = '0;
      check($sformatf("vec%0d_lat", i), lat, vecs[i].lat);
      check($sformatf("vec%0d_busy", i), busy, vecs[i].busy);
      wait_idle();
    end
    // enable gating: queued words drain, disabled strobes are dropped
    enable = 1'b1;
    trigger0(8'h40);
    tick();
    tick();
    expect_word(0, 8'h41);
    fast_strobe(0, 8'h41);
    expect_word(0, 8'h42);
    fast_strobe(0, 8'h42);
    enable = 1'b0;
    fast_strobe(1, 8'h3C);
    fast_strobe(0, 8'h3D);
    wait_idle();
    check("gate_drained", sb.size(), 0);
    check("gate_ovf", ovf, 0);
    // overflow: five ch1 edges inside one gap window
    enable = 1'b1;
    trigger0(8'h50);
    for (int k = 0; k < 5; k++) begin
      if (k < 4) expect_word(1, 8'(8'h61 + k));
      fast_strobe(1, 8'(8'h61 + k));
    end
    check("ovf_set", ovf, 2'b10);
    wait_idle();
    check("ovf_sticky", ovf, 2'b10);
    check("ovf_drained", sb.size(), 0);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("ovf_clr", ovf, 0);
    // full FIFO popped by ISSUE in the same cycle a new edge pushes
    trigger0(8'h70);
    for (int k = 0; k < 4; k++) begin
      expect_word(1, 8'(8'h71 + k));
      fast_strobe(1, 8'(8'h71 + k));
    end
    repeat (4) tick();
    expect_word(1, 8'h75);
    set_data(1, 8'h75);
    strobe[1] = 1'b1;
    tick();
    strobe[1] = 1'b0;
    wait_idle();
    check("bound_ovf", ovf, 0);
    check("bound_drained", sb.size(), 0);
    // strobe held high across reset release
    rst_n = 1'b0;
    strobe[1] = 1'b1;
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (6) tick();
    check("rst_held_busy", busy, 0);
    strobe = '0;
    repeat (3) tick();
    // reset during GAP with a word pending
    trigger0(8'h77);
    tick();
    fast_strobe(1, 8'h78);
    rst_n = 1'b0;
    tick();
    check("gap_rst_out", xfer_out, 0);
    check("gap_rst_byte", xfer_byte, 0);
    check("gap_rst_ch", xfer_ch, 0);
    check("gap_rst_busy", busy, 0);
    rst_n = 1'b1;
    repeat (30) tick();
    check("final_sb_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
